// File: rtl/main_bus_arbiter_pkg.sv
// Shared definitions for the main bus arbiter: FSM state encoding, the default
// burst length shared with the memory interface, and a counter-width helper.
package main_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BURST = 2'd2,
        ARB_TURN  = 2'd3
    } arb_state_t;

    localparam int unsigned ARB_BURST_LEN = 4;

    // $clog2 gives 0 for n==1; counters still need at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/main_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from ptr_i with wrap-around.
module main_bus_arbiter_rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] winner_o,
    output logic                 valid_o
);

    localparam int unsigned IdxW = $clog2(N);

    always_comb begin
        logic [IdxW:0] sum;
        logic          found;
        sum      = '0;
        found    = 1'b0;
        winner_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum = {1'b0, ptr_i} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(N)) begin
                sum = sum - (IdxW+1)'(N);
            end
            if (!found && req_i[sum[IdxW-1:0]]) begin
                found    = 1'b1;
                winner_o = sum[IdxW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter for the shared main bus: one address cycle plus a fixed
// data burst per tenure, a grant timeout, and a one-cycle turnaround.
module main_bus_arbiter
    import main_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned BURST_LEN   = ARB_BURST_LEN,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic                           clk,
    input  logic                           resetH,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           AddrValid,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int unsigned IdxW  = $clog2(NUM_MASTERS);
    localparam int unsigned BeatW = cnt_width(BURST_LEN);
    localparam int unsigned WaitW = cnt_width(TIMEOUT);

    arb_state_t             state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [IdxW-1:0]        pick_idx;
    logic                   pick_valid;

    main_bus_arbiter_rr_pick #(
        .N (NUM_MASTERS)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_GRANT;
                    owner_d    = pick_idx;
                    wait_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // AddrValid wins over a same-cycle request drop or timeout.
                if (AddrValid) begin
                    state_d    = ARB_BURST;
                    beat_cnt_d = '0;
                end else if (!req[owner_q]) begin
                    state_d = ARB_TURN;
                end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                    state_d       = ARB_TURN;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            ARB_BURST: begin
                if (beat_cnt_q == BeatW'(BURST_LEN - 1)) begin
                    state_d = ARB_TURN;
                end else begin
                    beat_cnt_d = beat_cnt_q + BeatW'(1);
                end
            end
            ARB_TURN: begin
                rr_ptr_d = (owner_q == IdxW'(NUM_MASTERS - 1)) ? '0 : owner_q + IdxW'(1);
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        gnt_d = '0;
        if (state_d == ARB_GRANT || state_d == ARB_BURST) begin
            gnt_d[owner_d] = 1'b1;
        end
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            gnt_q         <= gnt_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

    gnt_onehot0_a: assert property (@(posedge clk) disable iff (resetH) $onehot0(gnt_q));

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter: a per-cycle vector table on a 2-master
// instance plus hand sequences for async reset and 4-master wrap-around.
module tb_main_bus_arbiter;

    logic       clk = 1'b0;
    logic       resetH = 1'b1;
    logic [1:0] req = '0;
    logic       addr_valid = 1'b0;
    logic [1:0] gnt;
    logic [0:0] owner;
    logic       busy;
    logic       timeout_err;

    logic [3:0] req4 = '0;
    logic [3:0] gnt4;
    logic [1:0] owner4;
    logic       busy4;
    logic       timeout_err4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    main_bus_arbiter #(
        .NUM_MASTERS (2),
        .BURST_LEN   (4),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .resetH      (resetH),
        .req         (req),
        .AddrValid   (addr_valid),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    main_bus_arbiter #(
        .NUM_MASTERS (4),
        .BURST_LEN   (4),
        .TIMEOUT     (8)
    ) dut4 (
        .clk         (clk),
        .resetH      (resetH),
        .req         (req4),
        .AddrValid   (1'b0),
        .gnt         (gnt4),
        .owner       (owner4),
        .busy        (busy4),
        .timeout_err (timeout_err4)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       av;
        logic [1:0] gnt;
        logic       own;
        logic       busy;
        logic       terr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic [1:0] rq, input logic av,
                               input logic [1:0] g, input logic o, input logic b,
                               input logic t);
        vec_t r;
        r.rst = rst; r.req = rq; r.av = av;
        r.gnt = g; r.own = o; r.busy = b; r.terr = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive inputs, then sample #1 after the next rising edge.
    task automatic step(input logic rst, input logic [1:0] rq, input logic av);
        resetH     = rst;
        req        = rq;
        addr_valid = av;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, req, av | gnt, owner, busy, timeout_err
        tbl.push_back(v(1, 2'b00, 0, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b00, 0, 0, 0));
        // single master: 1 address + 4 beats, then turnaround
        tbl.push_back(v(0, 2'b01, 0, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b01, 1, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b01, 0, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b01, 0, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b01, 0, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b00, 0, 1, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b00, 0, 0, 0));
        // contention: pointer now at 1, so master 1 first
        tbl.push_back(v(0, 2'b11, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b11, 1, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b00, 1, 1, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b00, 1, 0, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b01, 0, 1, 0));
        // AddrValid held through burst and turnaround: no restart
        tbl.push_back(v(0, 2'b11, 1, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b11, 1, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b11, 1, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b11, 1, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b11, 1, 2'b00, 0, 1, 0));
        tbl.push_back(v(0, 2'b11, 1, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b10, 1, 1, 0));
        // early request drop in GRANT
        tbl.push_back(v(0, 2'b01, 0, 2'b00, 1, 1, 0));
        tbl.push_back(v(0, 2'b01, 0, 2'b00, 1, 0, 0));
        // timeout: 8 GRANT cycles then a single-cycle error pulse
        tbl.push_back(v(0, 2'b01, 0, 2'b01, 0, 1, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(v(0, 2'b01, 0, 2'b01, 0, 1, 0));
        tbl.push_back(v(0, 2'b01, 0, 2'b00, 0, 1, 1));
        tbl.push_back(v(0, 2'b11, 0, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 0, 2'b10, 1, 1, 0));
        // request drop during burst: all beats still granted
        tbl.push_back(v(0, 2'b10, 1, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b10, 1, 1, 0));
        tbl.push_back(v(0, 2'b00, 0, 2'b00, 1, 1, 0));
        // AddrValid in IDLE ignored
        tbl.push_back(v(0, 2'b00, 1, 2'b00, 1, 0, 0));
        tbl.push_back(v(0, 2'b00, 1, 2'b00, 1, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].av);
            chk($sformatf("vec%0d.gnt", i),   32'(gnt),         32'(tbl[i].gnt));
            chk($sformatf("vec%0d.owner", i), 32'(owner),       32'(tbl[i].own));
            chk($sformatf("vec%0d.busy", i),  32'(busy),        32'(tbl[i].busy));
            chk($sformatf("vec%0d.terr", i),  32'(timeout_err), 32'(tbl[i].terr));
        end

        // Async reset mid-burst, with the pointer at 1 beforehand.
        step(0, 2'b01, 0);
        chk("rst.pre_gnt0", 32'(gnt), 32'h1);
        step(0, 2'b00, 0);
        step(0, 2'b00, 0);
        step(0, 2'b10, 0);
        chk("rst.pre_gnt1", 32'(gnt), 32'h2);
        step(0, 2'b10, 1);
        step(0, 2'b10, 0);
        chk("rst.in_burst", 32'(gnt), 32'h2);
        #2;
        resetH = 1'b1;
        #1;
        chk("rst.async_gnt", 32'(gnt), 32'h0);
        chk("rst.async_owner", 32'(owner), 32'h0);
        chk("rst.async_busy", 32'(busy), 32'h0);
        step(1, 2'b11, 0);
        chk("rst.held_gnt", 32'(gnt), 32'h0);
        step(0, 2'b11, 0);
        chk("rst.ptr0_gnt", 32'(gnt), 32'h1);
        chk("rst.ptr0_owner", 32'(owner), 32'h0);
        step(0, 2'b00, 0);
        step(0, 2'b00, 0);
        chk("rst.idle_busy", 32'(busy), 32'h0);

        // Four masters: move pointer to 3, then 4'b1001 wins 3, then wraps to 0.
        req4 = 4'b0100;
        step(0, 2'b00, 0);
        chk("m4.gnt2", 32'(gnt4), 32'h4);
        chk("m4.own2", 32'(owner4), 32'h2);
        req4 = 4'b0000;
        step(0, 2'b00, 0);
        chk("m4.turn", 32'(gnt4), 32'h0);
        step(0, 2'b00, 0);
        req4 = 4'b1001;
        step(0, 2'b00, 0);
        chk("m4.gnt3", 32'(gnt4), 32'h8);
        chk("m4.own3", 32'(owner4), 32'h3);
        req4 = 4'b0000;
        step(0, 2'b00, 0);
        step(0, 2'b00, 0);
        chk("m4.idle_busy", 32'(busy4), 32'h0);
        req4 = 4'b1001;
        step(0, 2'b00, 0);
        chk("m4.gnt0", 32'(gnt4), 32'h1);
        chk("m4.own0", 32'(owner4), 32'h0);
        chk("m4.terr", 32'(timeout_err4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
